// File: rtl/restore_ctrl.sv
// Power-on restore sequencer: pops {value,addr} backup entries and writes them back to the wrappers.
// Optional RESTORE_SKIP_DUP_EN: drop later entries whose address was already restored this session.
module restore_ctrl #(
  parameter int K = 10,
  parameter int N = 32,
  parameter int C = 8,
  localparam int LOG2_K = $clog2(K)
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Pwr_off,
  input  logic                Start_Restore,
  input  logic                IsEmpty_Buffer,
  input  logic [N+LOG2_K-1:0] PopVal_Buffer,
  output logic                PopEn_Buffer,
  output logic [N-1:0]        Restore_Vin_IC_Reg_Wrapper,
  output logic [K-1:0]        Restore_Ens_IC_Reg_Wrapper,
  output logic                Restore_Busy,
  output logic                Restore_Done,
  output logic                Restore_Err,
  output logic [C-1:0]        Restore_Cnt
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    POP,
    LATCH,
    WRITE,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [N-1:0]      data_q;
  logic [LOG2_K-1:0] addr_q;
  logic              err_q;
  logic [C-1:0]      cnt_q;

  logic              clr;
  logic              start_ok;
  logic              addr_ok;
  logic              dup;
  logic              wr_en;
  logic [K-1:0]      sel;

  assign clr      = Rst | Pwr_off;
  assign start_ok = (state_q == IDLE) && Start_Restore;
  assign addr_ok  = int'(addr_q) < K;
  assign sel      = {{(K-1){1'b0}}, 1'b1} << addr_q;

`ifdef RESTORE_SKIP_DUP_EN
  logic [K-1:0] mask_q;

  assign dup = |(mask_q & sel);

  always_ff @(posedge Clk) begin
    if (clr) begin
      mask_q <= '0;
    end else if (start_ok) begin
      mask_q <= '0;
    end else if (wr_en) begin
      mask_q <= mask_q | sel;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign wr_en = (state_q == WRITE) && addr_ok && !dup;

  always_ff @(posedge Clk) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (Start_Restore) state_d = CHECK;
      CHECK: state_d = IsEmpty_Buffer ? DONE : POP;
      POP:   state_d = LATCH;
      LATCH: state_d = WRITE;
      WRITE: state_d = CHECK;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Popped entry is valid during LATCH, one cycle after the pop strobe
  always_ff @(posedge Clk) begin
    if (clr) begin
      data_q <= '0;
      addr_q <= '0;
    end else if (state_q == LATCH) begin
      data_q <= PopVal_Buffer[LOG2_K +: N];
      addr_q <= PopVal_Buffer[LOG2_K-1:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (clr) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_ok) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if ((state_q == WRITE) && !addr_ok) begin
        err_q <= 1'b1;
      end
      if (wr_en && (cnt_q != {C{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign PopEn_Buffer               = (state_q == POP);
  assign Restore_Vin_IC_Reg_Wrapper = data_q;
  assign Restore_Ens_IC_Reg_Wrapper = wr_en ? sel : '0;
  assign Restore_Busy               = (state_q != IDLE);
  assign Restore_Done               = (state_q == DONE);
  assign Restore_Err                = err_q;
  assign Restore_Cnt                = cnt_q;

endmodule

// File: tb/tb_restore_ctrl.sv
// Directed bench for restore_ctrl: empty start, ordered restore, bad address,
// duplicate address and power-off abort with Start while busy.
module tb_restore_ctrl;

  localparam int K = 10;
  localparam int N = 32;
  localparam int C = 8;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pwr_off = 1'b0;
  logic         start = 1'b0;
  logic         is_empty = 1'b1;
  logic [N+L-1:0] pop_val = '0;
  logic         pop_en;
  logic [N-1:0] vin;
  logic [K-1:0] ens;
  logic         busy;
  logic         done;
  logic         err;
  logic [C-1:0] cnt;

  int errors = 0;
  int checks = 0;
  int pops = 0;

  logic [N+L-1:0] q[$];
  logic [K-1:0]   ens_log[0:63];
  logic [N-1:0]   vin_log[0:63];
  logic           busy_log[0:63];
  logic           done_log[0:63];

  always #5 clk = ~clk;

  restore_ctrl #(.K(K), .N(N), .C(C)) dut (
    .Clk(clk),
    .Rst(rst),
    .Pwr_off(pwr_off),
    .Start_Restore(start),
    .IsEmpty_Buffer(is_empty),
    .PopVal_Buffer(pop_val),
    .PopEn_Buffer(pop_en),
    .Restore_Vin_IC_Reg_Wrapper(vin),
    .Restore_Ens_IC_Reg_Wrapper(ens),
    .Restore_Busy(busy),
    .Restore_Done(done),
    .Restore_Err(err),
    .Restore_Cnt(cnt)
  );

  task automatic service;
    if (pop_en === 1'b1) begin
      pops++;
      if (q.size() > 0) pop_val = q.pop_front();
    end
    is_empty = (q.size() == 0);
  endtask

  task automatic tick;
    @(negedge clk);
    service();
  endtask

  task automatic load(input logic [N+L-1:0] e);
    q.push_back(e);
    is_empty = 1'b0;
  endtask

  task automatic run_session(input int hold, output int done_at);
    for (int i = 0; i < 64; i++) begin
      ens_log[i] = '0;
      vin_log[i] = '0;
      busy_log[i] = 1'b0;
      done_log[i] = 1'b0;
    end
    done_at = -1;
    start = 1'b1;
    for (int c = 1; c < 60; c++) begin
      tick();
      ens_log[c] = ens;
      vin_log[c] = vin;
      busy_log[c] = busy;
      done_log[c] = done;
      start = (c <= hold);
      if (done === 1'b1 && done_at < 0) done_at = c;
      if (done_at > 0 && c >= done_at + 1) break;
    end
    start = 1'b0;
    checks++;
    if (done_at < 0) begin
      errors++;
      $display("FAIL session_timeout: no Done within budget, required Done");
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({pop_en, ens, vin, busy, done, err, cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: pop=%b ens=%h vin=%h busy=%b done=%b err=%b cnt=%0d required all 0",
               pop_en, ens, vin, busy, done, err, cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_empty_start;
    int d;
    int p0;
    p0 = pops;
    run_session(0, d);
    checks++;
    if (busy_log[1] !== 1'b1) begin
      errors++;
      $display("FAIL empty_busy_t1: got %b required 1", busy_log[1]);
    end
    checks++;
    if (d !== 2) begin
      errors++;
      $display("FAIL empty_done_time: got %0d required 2", d);
    end
    checks++;
    if (done_log[1] !== 1'b0 || done_log[3] !== 1'b0) begin
      errors++;
      $display("FAIL empty_done_pulse: t1=%b t3=%b required 0 0", done_log[1], done_log[3]);
    end
    checks++;
    if (pops - p0 !== 0 || cnt !== 8'd0) begin
      errors++;
      $display("FAIL empty_no_pop: pops=%0d cnt=%0d required 0 0", pops - p0, cnt);
    end
  endtask

  task automatic test_restore;
    int d;
    load({32'hA5A5A5A5, 4'd3});
    load({32'h00000001, 4'd0});
    load({32'hDEADBEEF, 4'd9});
    run_session(0, d);
    checks++;
    if (ens_log[4] !== 10'h008 || vin_log[4] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL restore_w0: ens=%h vin=%h required 008 a5a5a5a5", ens_log[4], vin_log[4]);
    end
    checks++;
    if (ens_log[8] !== 10'h001 || vin_log[8] !== 32'h00000001) begin
      errors++;
      $display("FAIL restore_w1: ens=%h vin=%h required 001 00000001", ens_log[8], vin_log[8]);
    end
    checks++;
    if (ens_log[12] !== 10'h200 || vin_log[12] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL restore_w2: ens=%h vin=%h required 200 deadbeef", ens_log[12], vin_log[12]);
    end
    checks++;
    if (ens_log[5] !== '0 || ens_log[6] !== '0 || ens_log[7] !== '0) begin
      errors++;
      $display("FAIL restore_gap: ens=%h %h %h required 0", ens_log[5], ens_log[6], ens_log[7]);
    end
    checks++;
    if (d !== 14) begin
      errors++;
      $display("FAIL restore_done_time: got %0d required 14", d);
    end
    checks++;
    if (cnt !== 8'd3 || err !== 1'b0) begin
      errors++;
      $display("FAIL restore_cnt_err: cnt=%0d err=%b required 3 0", cnt, err);
    end
  endtask

  task automatic test_bad_addr;
    int d;
    load({32'h00000055, 4'd12});
    load({32'h00000066, 4'd1});
    load({32'h00000077, 4'd0});
    run_session(0, d);
    checks++;
    if (ens_log[4] !== '0 || vin_log[4] !== 32'h55) begin
      errors++;
      $display("FAIL bad_addr_write: ens=%h vin=%h required 000 00000055", ens_log[4], vin_log[4]);
    end
    checks++;
    if (ens_log[8] !== 10'h002 || ens_log[12] !== 10'h001) begin
      errors++;
      $display("FAIL bad_addr_next: ens=%h %h required 002 001", ens_log[8], ens_log[12]);
    end
    tick();
    tick();
    checks++;
    if (err !== 1'b1 || cnt !== 8'd2) begin
      errors++;
      $display("FAIL bad_addr_err_cnt: err=%b cnt=%0d required 1 2", err, cnt);
    end
  endtask

  task automatic test_dup;
    int d;
    load({32'h00000011, 4'd2});
    load({32'h00000022, 4'd2});
    run_session(0, d);
    checks++;
    if (ens_log[4] !== 10'h004 || vin_log[4] !== 32'h11) begin
      errors++;
      $display("FAIL dup_first: ens=%h vin=%h required 004 00000011", ens_log[4], vin_log[4]);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL dup_err_cleared: got %b required 0", err);
    end
`ifdef RESTORE_SKIP_DUP_EN
    checks++;
    if (ens_log[8] !== '0 || cnt !== 8'd1) begin
      errors++;
      $display("FAIL dup_skip: ens=%h cnt=%0d required 000 1", ens_log[8], cnt);
    end
`else
    checks++;
    if (ens_log[8] !== 10'h004 || vin_log[8] !== 32'h22 || cnt !== 8'd2) begin
      errors++;
      $display("FAIL dup_both: ens=%h vin=%h cnt=%0d required 004 00000022 2",
               ens_log[8], vin_log[8], cnt);
    end
`endif
  endtask

  task automatic test_pwr_off;
    int d;
    int p0;
    load({32'h000000AB, 4'd5});
    load({32'h000000CD, 4'd6});
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (ens !== 10'h020) begin
      errors++;
      $display("FAIL pwr_off_pre_write: ens=%h required 020", ens);
    end
    pwr_off = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || ens !== '0 || cnt !== 8'd0 || vin !== '0) begin
      errors++;
      $display("FAIL pwr_off_abort: busy=%b ens=%h cnt=%0d vin=%h required 0 000 0 0",
               busy, ens, cnt, vin);
    end
    pwr_off = 1'b0;
    tick();
    p0 = pops;
    run_session(5, d);
    checks++;
    if (pops - p0 !== 1 || ens_log[4] !== 10'h040 || d !== 6) begin
      errors++;
      $display("FAIL busy_start_ignored: pops=%0d ens=%h done_at=%0d required 1 040 6",
               pops - p0, ens_log[4], d);
    end
    checks++;
    if (busy_log[d+1] !== 1'b0 || cnt !== 8'd1) begin
      errors++;
      $display("FAIL busy_start_idle: busy=%b cnt=%0d required 0 1", busy_log[d+1], cnt);
    end
  endtask

  initial begin
    test_reset();
    test_empty_start();
    test_restore();
    test_bad_addr();
    test_dup();
    test_pwr_off();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
